// File: rtl/phy_mdio_pkg.sv
// Shared types and frame constants for the Clause 22 MDIO master.
package phy_mdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_F,
        ST_PRE,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_DONE
    } mdio_state_t;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    localparam logic [5:0] HDR_BITS  = 6'd14;
    localparam logic [5:0] TA_BITS   = 6'd2;
    localparam logic [5:0] DATA_BITS = 6'd16;

    // Everything after the preamble, MSB first: ST, OP, PHY, REG, TA, DATA.
    // Reads carry zeros in the data field; those bits are never driven.
    function automatic logic [31:0] mdio_frame(input logic        rd,
                                               input logic [4:0]  phy,
                                               input logic [4:0]  regad,
                                               input logic [15:0] wdata);
        mdio_frame = {MDIO_ST, (rd ? MDIO_OP_RD : MDIO_OP_WR), phy, regad,
                      MDIO_TA_WR, (rd ? 16'h0000 : wdata)};
    endfunction

endpackage

// File: rtl/phy_mdio_if.sv
// Request/response bus between the PHY configuration logic and the MDIO master.
interface phy_mdio_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_rd;
    logic [4:0]  req_phy;
    logic [4:0]  req_reg;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;

    modport master (
        output req_valid, req_rd, req_phy, req_reg, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_rd, req_phy, req_reg, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mdio_clk_gen.sv
// Free-running MDC divider; ticks flag the cycle whose closing edge toggles MDC.
module mdio_clk_gen #(
    parameter int MDC_HALF = 25
) (
    input  logic rgmii_clk_in,
    input  logic sys_rst,
    output logic mdc_out,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int               CNT_W    = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDC_HALF - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap      = (cnt == CNT_LAST);
    assign rise_tick = wrap && !mdc_out;
    assign fall_tick = wrap &&  mdc_out;

    // Half-period counter; MDC toggles each time it wraps.
    always_ff @(posedge rgmii_clk_in) begin
        if (sys_rst) begin
            cnt     <= '0;
            mdc_out <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            mdc_out <= ~mdc_out;
        end else begin
            cnt     <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/phy_mdio_ctrl.sv
// Clause 22 MDIO master: serialises one read/write request per frame.
module phy_mdio_ctrl
    import phy_mdio_pkg::*;
#(
    parameter int MDC_HALF = 25,
    parameter int PRE_LEN  = 32
) (
    input  logic       rgmii_clk_in,
    input  logic       sys_rst,
    phy_mdio_if.slave  cmd,
    output logic       mdc_out,
    output logic       mdio_o,
    output logic       mdio_t,
    input  logic       mdio_i
);

    localparam logic [5:0] PRE_CNT = 6'(PRE_LEN - 1);

    logic        rise_tick;
    logic        fall_tick;

    mdio_state_t state, state_nxt;
    logic [5:0]  bit_cnt, bit_cnt_nxt;
    logic [31:0] tx_sh, tx_sh_nxt;
    logic        rd_q, rd_nxt;
    logic        mdio_o_nxt, mdio_t_nxt;
    logic        rsp_valid_nxt;
    logic [15:0] rsp_rdata_nxt;
    logic [15:0] rx_sh;
    logic        mdio_i_p0, mdio_i_p1;
    logic        tx_bit;

    mdio_clk_gen #(.MDC_HALF(MDC_HALF)) u_clk_gen (
        .rgmii_clk_in (rgmii_clk_in),
        .sys_rst      (sys_rst),
        .mdc_out      (mdc_out),
        .rise_tick    (rise_tick),
        .fall_tick    (fall_tick)
    );

    assign cmd.req_ready = (state == ST_IDLE);

    // During a read the line is released from TA onward, so keep the idle level.
    assign tx_bit = rd_q ? 1'b1 : tx_sh[31];

    // Next-state and output decode; outbound bits only move on fall_tick.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        tx_sh_nxt     = tx_sh;
        rd_nxt        = rd_q;
        mdio_o_nxt    = mdio_o;
        mdio_t_nxt    = mdio_t;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = cmd.rsp_rdata;
        unique case (state)
            ST_IDLE: begin
                if (cmd.req_valid) begin
                    state_nxt = ST_WAIT_F;
                    rd_nxt    = cmd.req_rd;
                    tx_sh_nxt = mdio_frame(cmd.req_rd, cmd.req_phy, cmd.req_reg, cmd.req_wdata);
                end
            end
            ST_WAIT_F: begin
                if (fall_tick) begin
                    state_nxt   = ST_PRE;
                    bit_cnt_nxt = PRE_CNT;
                    mdio_o_nxt  = 1'b1;
                    mdio_t_nxt  = 1'b0;
                end
            end
            ST_PRE: begin
                if (fall_tick) begin
                    if (bit_cnt == 6'd0) begin
                        state_nxt   = ST_HDR;
                        bit_cnt_nxt = HDR_BITS - 6'd1;
                        mdio_o_nxt  = tx_sh[31];
                        tx_sh_nxt   = {tx_sh[30:0], 1'b0};
                    end else begin
                        bit_cnt_nxt = bit_cnt - 6'd1;
                    end
                end
            end
            ST_HDR: begin
                if (fall_tick) begin
                    if (bit_cnt == 6'd0) begin
                        state_nxt   = ST_TA;
                        bit_cnt_nxt = TA_BITS - 6'd1;
                        mdio_o_nxt  = tx_bit;
                        mdio_t_nxt  = rd_q;
                    end else begin
                        bit_cnt_nxt = bit_cnt - 6'd1;
                        mdio_o_nxt  = tx_sh[31];
                    end
                    tx_sh_nxt = {tx_sh[30:0], 1'b0};
                end
            end
            ST_TA: begin
                if (fall_tick) begin
                    if (bit_cnt == 6'd0) begin
                        state_nxt   = ST_DATA;
                        bit_cnt_nxt = DATA_BITS - 6'd1;
                    end else begin
                        bit_cnt_nxt = bit_cnt - 6'd1;
                    end
                    mdio_o_nxt = tx_bit;
                    tx_sh_nxt  = {tx_sh[30:0], 1'b0};
                end
            end
            ST_DATA: begin
                if (fall_tick) begin
                    if (bit_cnt == 6'd0) begin
                        state_nxt  = ST_DONE;
                        mdio_o_nxt = 1'b1;
                        mdio_t_nxt = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt - 6'd1;
                        mdio_o_nxt  = tx_bit;
                        tx_sh_nxt   = {tx_sh[30:0], 1'b0};
                    end
                end
            end
            ST_DONE: begin
                if (fall_tick) begin
                    state_nxt     = ST_IDLE;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = rd_q ? rx_sh : 16'h0000;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control state and pad-facing outputs; reset abandons any frame in flight.
    always_ff @(posedge rgmii_clk_in) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            bit_cnt       <= 6'd0;
            mdio_o        <= 1'b1;
            mdio_t        <= 1'b1;
            cmd.rsp_valid <= 1'b0;
            cmd.rsp_rdata <= 16'h0000;
        end else begin
            state         <= state_nxt;
            bit_cnt       <= bit_cnt_nxt;
            mdio_o        <= mdio_o_nxt;
            mdio_t        <= mdio_t_nxt;
            cmd.rsp_valid <= rsp_valid_nxt;
            cmd.rsp_rdata <= rsp_rdata_nxt;
        end
    end

    // Frame shift register and request type; only meaningful outside IDLE.
    always_ff @(posedge rgmii_clk_in) begin
        tx_sh <= tx_sh_nxt;
        rd_q  <= rd_nxt;
    end

    // Two-flop synchroniser for the asynchronous pad input.
    always_ff @(posedge rgmii_clk_in) begin
        mdio_i_p0 <= mdio_i;
        mdio_i_p1 <= mdio_i_p0;
    end

    // Read data is captured on MDC rising edges, MSB first.
    always_ff @(posedge rgmii_clk_in) begin
        if (state == ST_DATA && rise_tick) begin
            rx_sh <= {rx_sh[14:0], mdio_i_p1};
        end
    end

endmodule
